output_bit_vector_loader: RTL

- Driving end of the learned output-bit circuits: streams 32-bit words, assembles the 1894-bit input vector, presents it on `vec_o` to the `module_output_bit_*` instances and samples their result bit.
- Compares each result against an expected bit and keeps test and error counts, so accuracy is measured in hardware.
- Sits between the host/DMA vector stream and the combinational bit modules.

---
 rtl/output_bit_vector_loader.sv | 132 +++++++++++++
 1 files changed

// File: rtl/output_bit_vector_loader.sv
// Assembles a wide input vector from a word stream, holds it stable for the bit modules,
// then samples their result bit against an expected bit and keeps saturating counts.
module output_bit_vector_loader #(
  parameter int unsigned IN_WIDTH   = 1894,
  parameter int unsigned WORD_W     = 32,
  parameter int unsigned SETTLE_CYC = 2,
  parameter int unsigned CNT_W      = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [WORD_W-1:0]   s_data,
  input  logic                s_last,
  input  logic                s_exp,
  output logic [IN_WIDTH-1:0] vec_o,
  input  logic                dut_o,
  output logic                res_valid,
  output logic                res_match,
  output logic                frame_err,
  input  logic                clear,
  output logic [CNT_W-1:0]    test_count,
  output logic [CNT_W-1:0]    err_count
);

  localparam int unsigned WORDS     = (IN_WIDTH + WORD_W - 1) / WORD_W;
  localparam int unsigned LAST_BITS = IN_WIDTH - (WORDS - 1) * WORD_W;
  localparam int unsigned KW        = $clog2(WORDS);
  localparam int unsigned SHW       = (WORDS - 1) * WORD_W;
  localparam int unsigned SW        = 4;
  localparam logic [KW-1:0] LastIdx = KW'(WORDS - 1);

  typedef enum logic [1:0] {StLoad, StSettle, StCheck, StDrain} state_e;

  state_e            state;
  logic [KW-1:0]     k;
  logic [SW-1:0]     settle_cnt;
  logic              exp_q;
  logic [WORD_W-1:0] shadow [WORDS-1];
  logic [SHW-1:0]    shadow_flat;

  always_comb begin
    shadow_flat = '0;
    for (int i = 0; i < int'(WORDS) - 1; i++) begin
      shadow_flat[i*WORD_W +: WORD_W] = shadow[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= StLoad;
      k          <= '0;
      settle_cnt <= '0;
      exp_q      <= 1'b0;
      s_ready    <= 1'b0;
      vec_o      <= '0;
      res_valid  <= 1'b0;
      res_match  <= 1'b0;
      frame_err  <= 1'b0;
      test_count <= '0;
      err_count  <= '0;
      for (int i = 0; i < int'(WORDS) - 1; i++) begin
        shadow[i] <= '0;
      end
    end else begin
      res_valid <= 1'b0;
      frame_err <= 1'b0;
      unique case (state)
        StLoad: begin
          s_ready <= 1'b1;
          if (s_valid && s_ready) begin
            if (k == LastIdx) begin
              k <= '0;
              if (s_last) begin
                // Final beat goes straight to vec_o so the whole vector changes in one edge.
                vec_o      <= {s_data[LAST_BITS-1:0], shadow_flat};
                exp_q      <= s_exp;
                settle_cnt <= SW'(SETTLE_CYC - 1);
                s_ready    <= 1'b0;
                state      <= StSettle;
              end else begin
                frame_err <= 1'b1;
                state     <= StDrain;
              end
            end else if (s_last) begin
              frame_err <= 1'b1;
              k         <= '0;
            end else begin
              shadow[k] <= s_data;
              k         <= k + 1'b1;
            end
          end
        end
        StDrain: begin
          s_ready <= 1'b1;
          if (s_valid && s_ready && s_last) begin
            k     <= '0;
            state <= StLoad;
          end
        end
        StSettle: begin
          s_ready <= 1'b0;
          if (settle_cnt == '0) begin
            state <= StCheck;
          end else begin
            settle_cnt <= settle_cnt - 1'b1;
          end
        end
        StCheck: begin
          res_valid <= 1'b1;
          res_match <= (dut_o == exp_q);
          s_ready   <= 1'b1;
          k         <= '0;
          state     <= StLoad;
          if (test_count != '1) begin
            test_count <= test_count + 1'b1;
          end
          // err_count can never pass test_count since both stop at all-ones.
          if ((dut_o != exp_q) && (err_count != '1)) begin
            err_count <= err_count + 1'b1;
          end
        end
        default: state <= StLoad;
      endcase
      if (clear) begin
        test_count <= '0;
        err_count  <= '0;
      end
    end
  end

endmodule
